bw_pack4: RTL and testbench

Downstream stage of the black-and-white conversion path. Takes the 8-bit gray pixel stream produced by the divide-by-3 stage (one byte per pixel, valid/ready handshake) and packs four consecutive pixels into a 32-bit word for the frame-buffer write port. It counts pixels per frame and flushes a partial final word with byte enables. It marks the last word of each frame and pulses `done` when the frame has fully drained.

---
 rtl/bw_pkg.sv | 31 +++
 rtl/bw_word_reg.sv | 56 +++++
 rtl/bw_pack4.sv | 110 +++++++++++
 tb/tb_bw_pack4.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_pkg.sv
// rtl/bw_pkg.sv - shared widths, pack FSM states and lane helpers for the B/W packer
package bw_pkg;
  localparam int PIXEL_W = 8;
  localparam int WORD_W  = 32;
  localparam int LANES   = 4;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} bw_pack_state_t;

  // Lanes below idx come from the accumulator, lane idx is the completing pixel, the rest are zero.
  function automatic logic [WORD_W-1:0] pack_word(input logic [23:0] acc, input logic [1:0] idx,
                                                  input logic [PIXEL_W-1:0] gray);
    logic [WORD_W-1:0] ext;
    logic [WORD_W-1:0] w;
    ext = {8'h00, acc};
    w   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(idx)) w[8*k +: 8] = ext[8*k +: 8];
      else if (k == int'(idx)) w[8*k +: 8] = gray;
    end
    return w;
  endfunction

  function automatic logic [LANES-1:0] byte_en(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/bw_word_reg.sv
// rtl/bw_word_reg.sv - output word holding register with valid/ready hold and be/last sidecar
module bw_word_reg
  import bw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [LANES-1:0]  be_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic [LANES-1:0]  be_o,
  output logic              last_o
);
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [LANES-1:0]  be_q, be_d;
  logic              last_q, last_d;

  // Load only arrives when the register is empty or being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      be_d    = be_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign be_o    = be_q;
  assign last_o  = last_q;
endmodule

// File: rtl/bw_pack4.sv
// rtl/bw_pack4.sv - packs four gray pixels per 32-bit word, flushing a partial last word per frame
module bw_pack4
  import bw_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_gray,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [LANES-1:0]   out_be,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  bw_pack_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       acc_q, acc_d;
  logic              done_q, done_d;
  logic              accept, last_pix, load;
  logic [WORD_W-1:0] word;
  logic [LANES-1:0]  be;

  assign in_ready = (state_q == FILL) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (cnt_q == LAST_IDX);
  assign load     = accept && ((idx_q == 2'd3) || last_pix);
  assign word     = pack_word(acc_q, idx_q, in_gray);
  assign be       = byte_en(idx_q);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    acc_d[7:0]   = in_gray;
            2'd1:    acc_d[15:8]  = in_gray;
            2'd2:    acc_d[23:16] = in_gray;
            default: ;
          endcase
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The only word left in the register here is the frame's last one.
        if (out_valid && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  bw_word_reg u_word (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (word),
    .be_i    (be),
    .last_i  (last_pix),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .be_o    (out_be),
    .last_o  (out_last)
  );
endmodule

// File: tb/tb_bw_pack4.sv
// tb/tb_bw_pack4.sv - directed and randomized checks of bw_pack4 at several frame sizes
module tb_bw_pack4;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a[4], iv_a[4], ir_a[4], ov_a[4], or_a[4], ol_a[4], busy_a[4], done_a[4];
  logic [7:0]  ig_a[4];
  logic [31:0] od_a[4];
  logic [3:0]  obe_a[4];

  // Instances 0..3 use frame sizes 8, 6, 1 and 13.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int FP = (g == 0) ? 8 : (g == 1) ? 6 : (g == 2) ? 1 : 13;
    bw_pack4 #(.FRAME_PIXELS(FP), .CNT_W(5)) u_dut (
      .clk(clk), .rst(rst), .start(start_a[g]), .in_valid(iv_a[g]), .in_ready(ir_a[g]),
      .in_gray(ig_a[g]), .out_valid(ov_a[g]), .out_ready(or_a[g]), .out_data(od_a[g]),
      .out_be(obe_a[g]), .out_last(ol_a[g]), .busy(busy_a[g]), .done(done_a[g])
    );
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  pix_q[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_b[$];
  logic        got_l[$];
  int          done_cnt, done_lat, stall_seen;
  logic        timed_out, stall_ir, stall_chg, busy_at_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame from pix_q and records every word handshake and done pulse.
  task automatic run_frame(input int sel, input int fp, input int vpct, input int rpct, input int stall);
    int sent, cyc, stall_left, hs_cyc, dn_cyc;
    logic stalling;
    logic [31:0] held;
    sent = 0; cyc = 0; stall_left = stall; hs_cyc = -100; dn_cyc = -1; held = '0;
    got_d.delete(); got_b.delete(); got_l.delete();
    done_cnt = 0; timed_out = 1'b0; stall_ir = 1'b0; stall_chg = 1'b0; stall_seen = 0;
    busy_at_done = 1'b1;
    start_a[sel] = 1'b1;
    tick();
    start_a[sel] = 1'b0;
    while (done_cnt == 0 && !timed_out) begin
      iv_a[sel] = (sent < fp) && ($urandom_range(99) < vpct);
      ig_a[sel] = (sent < fp) ? pix_q[sent] : 8'h00;
      stalling = ov_a[sel] && (stall_left > 0);
      if (stalling) begin
        if (stall_left == stall) held = od_a[sel];
        stall_left--;
        stall_seen++;
        or_a[sel] = 1'b0;
      end else begin
        or_a[sel] = ($urandom_range(99) < rpct);
      end
      @(negedge clk);
      if (stalling && ir_a[sel]) stall_ir = 1'b1;
      if (stalling && od_a[sel] !== held) stall_chg = 1'b1;
      if (iv_a[sel] && ir_a[sel]) sent++;
      if (ov_a[sel] && or_a[sel]) begin
        got_d.push_back(od_a[sel]);
        got_b.push_back(obe_a[sel]);
        got_l.push_back(ol_a[sel]);
        if (ol_a[sel]) hs_cyc = cyc;
      end
      if (done_a[sel]) begin
        done_cnt++;
        dn_cyc = cyc;
        busy_at_done = busy_a[sel];
      end
      tick();
      cyc++;
      if (cyc >= 3000) timed_out = 1'b1;
    end
    iv_a[sel] = 1'b0;
    @(negedge clk);
    if (done_a[sel]) done_cnt++;
    tick();
    done_lat = dn_cyc - hs_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 4; s++) begin
      tests_run++;
      if ({ir_a[s], ov_a[s], od_a[s], obe_a[s], ol_a[s], busy_a[s], done_a[s]} !== 41'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got ir=%b ov=%b data=%h be=%h last=%b busy=%b done=%b, expected all zero",
                 s, ir_a[s], ov_a[s], od_a[s], obe_a[s], ol_a[s], busy_a[s], done_a[s]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic8();
    pix_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(0, 8, 100, 100, 0);
    tests_run++;
    if (timed_out || got_d.size() != 2) begin
      tests_failed++;
      $display("FAIL basic8_count: got %0d words timeout=%b, expected 2 words", got_d.size(), timed_out);
    end else begin
      tests_run++;
      if ({got_d[0], got_b[0], got_l[0]} !== {32'h04030201, 4'hF, 1'b0}) begin
        tests_failed++;
        $display("FAIL basic8_w0: got %h/%h/%b expected 04030201/f/0", got_d[0], got_b[0], got_l[0]);
      end
      tests_run++;
      if ({got_d[1], got_b[1], got_l[1]} !== {32'h08070605, 4'hF, 1'b1}) begin
        tests_failed++;
        $display("FAIL basic8_w1: got %h/%h/%b expected 08070605/f/1", got_d[1], got_b[1], got_l[1]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_lat !== 1 || busy_at_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic8_done: got count=%0d lat=%0d busy=%b expected 1/1/0", done_cnt, done_lat, busy_at_done);
    end
  endtask

  task automatic test_partial6();
    pix_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(1, 6, 100, 100, 0);
    tests_run++;
    if (timed_out || got_d.size() != 2) begin
      tests_failed++;
      $display("FAIL partial6_count: got %0d words timeout=%b, expected 2 words", got_d.size(), timed_out);
    end else begin
      tests_run++;
      if ({got_d[0], got_b[0], got_l[0]} !== {32'hA3A2A1A0, 4'hF, 1'b0}) begin
        tests_failed++;
        $display("FAIL partial6_w0: got %h/%h/%b expected a3a2a1a0/f/0", got_d[0], got_b[0], got_l[0]);
      end
      tests_run++;
      if ({got_d[1], got_b[1], got_l[1]} !== {32'h0000A5A4, 4'h3, 1'b1}) begin
        tests_failed++;
        $display("FAIL partial6_w1: got %h/%h/%b expected 0000a5a4/3/1", got_d[1], got_b[1], got_l[1]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_lat !== 1) begin
      tests_failed++;
      $display("FAIL partial6_done: got count=%0d lat=%0d expected 1/1", done_cnt, done_lat);
    end
  endtask

  task automatic test_backpressure();
    pix_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(0, 8, 100, 100, 5);
    tests_run++;
    if (stall_seen !== 5 || stall_ir !== 1'b0 || stall_chg !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_stall: got cycles=%0d in_ready_seen=%b data_changed=%b expected 5/0/0",
               stall_seen, stall_ir, stall_chg);
    end
    tests_run++;
    if (timed_out || got_d.size() != 2) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d words timeout=%b, expected 2 words", got_d.size(), timed_out);
    end else begin
      tests_run++;
      if ({got_d[0], got_b[0], got_l[0], got_d[1], got_b[1], got_l[1]} !==
          {32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b1}) begin
        tests_failed++;
        $display("FAIL bp_words: got %h/%h/%b %h/%h/%b expected 04030201/f/0 08070605/f/1",
                 got_d[0], got_b[0], got_l[0], got_d[1], got_b[1], got_l[1]);
      end
    end
  endtask

  task automatic test_single();
    or_a[2] = 1'b0;
    start_a[2] = 1'b1;
    tick();
    start_a[2] = 1'b0;
    iv_a[2] = 1'b1;
    ig_a[2] = 8'h7F;
    tick();
    iv_a[2] = 1'b0;
    tests_run++;
    if ({ov_a[2], od_a[2], obe_a[2], ol_a[2], busy_a[2], ir_a[2]} !== {1'b1, 32'h0000007F, 4'h1, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_word: got ov=%b %h/%h/%b busy=%b ir=%b expected 1 0000007f/1/1 busy=1 ir=0",
               ov_a[2], od_a[2], obe_a[2], ol_a[2], busy_a[2], ir_a[2]);
    end
    start_a[2] = 1'b1;
    tick();
    start_a[2] = 1'b0;
    tick();
    tests_run++;
    if ({ov_a[2], od_a[2], busy_a[2], done_a[2]} !== {1'b1, 32'h0000007F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_drain_start: got ov=%b data=%h busy=%b done=%b expected 1/0000007f/1/0",
               ov_a[2], od_a[2], busy_a[2], done_a[2]);
    end
    or_a[2] = 1'b1;
    tick();
    tests_run++;
    if ({done_a[2], busy_a[2], ov_a[2]} !== 3'b100) begin
      tests_failed++;
      $display("FAIL single_done: got done=%b busy=%b ov=%b expected 1/0/0", done_a[2], busy_a[2], ov_a[2]);
    end
    tick();
    tests_run++;
    if (done_a[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_pulse: got done=%b expected 0", done_a[2]);
    end
    pix_q = '{8'h55};
    run_frame(2, 1, 100, 100, 0);
    tests_run++;
    if (got_d.size() != 1 || {got_d[0], got_b[0], got_l[0]} !== {32'h00000055, 4'h1, 1'b1} || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL single_rerun: got %0d words first=%h done=%0d expected 1 word 00000055/1/1 done 1",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 32'h0, done_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    or_a[0] = 1'b1;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    iv_a[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ig_a[0] = 8'h01 + 8'(i);
      tick();
    end
    iv_a[0] = 1'b0;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({ir_a[0], ov_a[0], od_a[0], obe_a[0], ol_a[0], busy_a[0], done_a[0]} !== 41'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got ir=%b ov=%b data=%h be=%h last=%b busy=%b done=%b expected all zero",
               ir_a[0], ov_a[0], od_a[0], obe_a[0], ol_a[0], busy_a[0], done_a[0]);
    end
    rst = 1'b0;
    tick();
    pix_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run_frame(0, 8, 100, 100, 0);
    tests_run++;
    if (got_d.size() != 2) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d words expected 2", got_d.size());
    end else begin
      tests_run++;
      if ({got_d[0], got_d[1], got_l[0], got_l[1]} !== {32'h14131211, 32'h18171615, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL midreset_words: got %h %h last %b%b expected 14131211 18171615 last 01",
                 got_d[0], got_d[1], got_l[0], got_l[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic [3:0]  eb;
    for (int f = 0; f < 1000; f++) begin
      pix_q.delete();
      for (int i = 0; i < 13; i++) pix_q.push_back(8'($urandom));
      run_frame(3, 13, 70, 70, 0);
      tests_run++;
      if (timed_out || got_d.size() != 4 || done_cnt !== 1 || done_lat !== 1) begin
        tests_failed++;
        $display("FAIL rand_frame%0d: got words=%0d done=%0d lat=%0d timeout=%b expected 4/1/1/0",
                 f, got_d.size(), done_cnt, done_lat, timed_out);
      end else begin
        for (int w = 0; w < 4; w++) begin
          ed = '0;
          eb = '0;
          for (int k = 0; k < 4; k++) begin
            if (4 * w + k < 13) begin
              ed[8*k +: 8] = pix_q[4*w+k];
              eb[k] = 1'b1;
            end
          end
          tests_run++;
          if ({got_d[w], got_b[w], got_l[w]} !== {ed, eb, (w == 3)}) begin
            tests_failed++;
            $display("FAIL rand_frame%0d_w%0d: got %h/%h/%b expected %h/%h/%b",
                     f, w, got_d[w], got_b[w], got_l[w], ed, eb, (w == 3));
          end
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      start_a[s] = 1'b0;
      iv_a[s] = 1'b0;
      or_a[s] = 1'b0;
      ig_a[s] = 8'h00;
    end
    test_reset();
    test_basic8();
    test_partial6();
    test_backpressure();
    test_single();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
